// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store path: FSM states, RISC-V width codes
// and the per-access legality helpers used when a request is accepted.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths only exist for loads.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~off[0];
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: extract and extend a load from a memory word, and splice
// store data into the addressed byte/halfword of a word.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and load extension.
  always_comb begin
    case (byte_off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'd0, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = word;
    endcase
  end

  // Store merge: only the addressed lane(s) change.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged = word;
        endcase
      end
      F3_H: begin
        if (byte_off[1]) begin
          merged[31:16] = wdata;
        end else begin
          merged[15:0] = wdata;
        end
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide data memory with
// combinational read; sub-word stores are done as read-merge-write.
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_r, state_next_s;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        accept_s;
  logic        err_s;
  logic [31:0] load_s;
  logic [31:0] merged_s;

  assign accept_s = req_valid & (state_r == ST_IDLE);
  assign err_s    = ~funct3_legal(req_we, req_funct3)
                  | ~addr_aligned(req_funct3, req_addr[1:0])
                  | ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  lsu_align u_align (
    .word      (mem_read_data),
    .byte_off  (addr_r[1:0]),
    .funct3    (f3_r),
    .wdata     (wdata_r[15:0]),
    .load_data (load_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s)        state_next_s = ST_IDLE;
        else if (err_s)       state_next_s = ST_RESP;
        else if (!req_we)     state_next_s = ST_LOAD;
        else if (req_funct3 == F3_W) state_next_s = ST_WRITE;
        else                  state_next_s = ST_MERGE;
      end
      ST_LOAD:  state_next_s = ST_RESP;
      ST_MERGE: state_next_s = ST_WRITE;
      ST_WRITE: state_next_s = ST_RESP;
      ST_RESP:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the write strobe is killed by reset in the same cycle.
  always_comb begin
    req_ready      = (state_r == ST_IDLE);
    resp_valid     = (state_r == ST_RESP);
    mem_write      = (state_r == ST_WRITE) & ~rst;
    mem_write_data = wdata_r;
    resp_rdata     = rdata_r;
    resp_err       = err_r;
    if (state_r == ST_IDLE) begin
      mem_address = 32'd0;
    end else begin
      mem_address = {addr_r[31:2], 2'b00};
    end
  end

  // Request latch, load capture and store merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_r    <= 3'd0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            rdata_r <= 32'd0;
            err_r   <= err_s;
          end
        end
        ST_LOAD:  rdata_r <= load_s;
        ST_MERGE: wdata_r <= merged_s;
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of addressable 32-bit data-memory words.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  core presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RISC-V width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal-funct3 access; valid with resp_valid.
REQ-013 SHALL have port mem_write  output  1  word write strobe to data memory.
REQ-014 SHALL have port mem_address  output  32  word-aligned byte address to data memory.
REQ-015 SHALL have port mem_write_data  output  32  full word to write.
REQ-016 SHALL have port mem_read_data  input  32  combinational word read of mem_address.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE, RESP.
REQ-018 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; request fields latched at handshake.
REQ-019 SHALL, at handshake, flag error if funct3 illegal for the direction, halfword addr[0]!=0, word addr[1:0]!=0, or addr[31:2] >= DEPTH_WORDS; error -> RESP with resp_err=1, no memory write.
REQ-020 SHALL route valid load -> LOAD, valid SW -> WRITE, valid SB/SH -> MERGE.
REQ-021 SHALL in LOAD capture mem_read_data, select byte/halfword by addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), -> RESP.
REQ-022 SHALL in MERGE read the word and replace only the addressed byte/halfword with low bits of req_wdata -> WRITE.
REQ-023 SHALL in WRITE assert mem_write=1 for exactly one cycle with merged/full word on mem_write_data -> RESP.
REQ-024 SHALL in RESP assert resp_valid=1 for exactly one cycle -> IDLE; next request accepted the cycle after RESP.
REQ-025 SHALL give latency handshake-to-resp_valid: error 1, load 2, SW 2, SB/SH 3 cycles.
REQ-026 SHALL drive mem_address = {latched addr[31:2],2'b00} outside IDLE and 0 in IDLE; mem_write=0 outside WRITE.
REQ-027 SHALL hold resp_rdata and resp_err stable from RESP until the next handshake.

Reset
REQ-028 SHALL on rst: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-029 SHALL gate mem_write with ~rst so reset in WRITE aborts the write; reset in any state discards the access without response.
REQ-030 SHALL ignore req_valid during a reset cycle.

Structure
REQ-031 SHALL place state encoding and funct3 constants in shared package cpu_pkg.
REQ-032 SHALL use one sub-module, lsu_align, holding combinational byte-lane extract/extend and merge logic.

Verification
REQ-033 SHALL check: mem word 0x40 = 0x8899AABB; LB addr 0x41 -> resp_rdata 0xFFFFFFAA at cycle 2; LBU -> 0x000000AA.
REQ-034 SHALL check: SH 0x42 data 0x00001234 over 0x8899AABB -> one mem_write of 0x1234AABB at cycle 2, resp_valid at cycle 3.
REQ-035 SHALL check: LW 0x43 -> resp_err=1 at cycle 1, resp_rdata 0, mem_write never asserted.
REQ-036 SHALL check: SW addr 0x400 (DEPTH_WORDS=256) -> resp_err=1, memory unchanged.
REQ-037 SHALL check: rst asserted while in WRITE of SB -> no mem_write, no resp_valid, req_ready=1 next cycle.
REQ-038 SHALL check: back-to-back SW then LW same address with req_valid held high -> second accepted cycle after RESP, returns stored value.
